// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, grant source
// and the arbitration rule applied both from IDLE and on access completion.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } grant_src_e;

    // Data side wins ties unless the fetch side has already waited the
    // maximum number of data grants.
    function automatic arb_state_e arb_pick(input logic if_r,
                                            input logic dm_r,
                                            input logic starved);
        if (dm_r && !(if_r && starved)) return GNT_DM;
        if (if_r) return GNT_IF;
        return IDLE;
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data-side grants issued while fetch keeps waiting.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX_V = CW'(STARVE_MAX);

    logic [CW-1:0] cnt;

    // Clear has priority; increment stops at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data stages of the pipeline onto one memory port.
// Grants are held until mem_ack; results come back as one-cycle valid pulses.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [AW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [AW-1:0] dm_wdata,
    output logic [AW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          stall_f,
    output logic          stall_m,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata,
    input  logic          mem_ack
);

    arb_state_e state;
    arb_state_e nxt;
    grant_src_e src;
    logic       served_req;
    logic       done;
    logic       grant_new;
    logic       aborted;
    logic       at_max;
    logic       cnt_inc;
    logic       cnt_clr;

    // Next-state decision. On completion the side just served is only
    // reconsidered when the other side is also waiting; a lone request from
    // it is still the stale one for the access being completed.
    always_comb begin
        nxt        = state;
        src        = SRC_IF;
        served_req = 1'b0;
        case (state)
            IDLE: begin
                nxt = arb_pick(if_req, dm_req, at_max);
            end
            GNT_IF: begin
                src        = SRC_IF;
                served_req = if_req;
                if (mem_ack) nxt = arb_pick(if_req & dm_req, dm_req, at_max);
            end
            GNT_DM: begin
                src        = SRC_DM;
                served_req = dm_req;
                if (mem_ack) nxt = arb_pick(if_req, dm_req & if_req, at_max);
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    assign done      = (state != IDLE) && mem_ack;
    assign grant_new = (nxt != IDLE) && ((state == IDLE) || done);
    assign cnt_inc   = grant_new && (nxt == GNT_DM) && if_req;
    assign cnt_clr   = (grant_new && (nxt == GNT_IF)) || !if_req;

    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .at_max(at_max)
    );

    // Grant FSM with registered memory-side outputs, read-data capture and
    // valid pulses; a requester that drops out mid-grant gets no pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state    <= nxt;
            mem_req  <= (nxt != IDLE);
            if_valid <= 1'b0;
            dm_valid <= 1'b0;

            if (done) begin
                if (src == SRC_IF) begin
                    if_rdata <= mem_rdata;
                    if_valid <= served_req & ~aborted;
                end else begin
                    if (!mem_we) dm_rdata <= mem_rdata;
                    dm_valid <= served_req & ~aborted;
                end
            end

            if (grant_new || (nxt == IDLE)) begin
                aborted <= 1'b0;
            end else begin
                aborted <= aborted | ~served_req;
            end

            if (grant_new) begin
                if (nxt == GNT_DM) begin
                    mem_addr  <= dm_addr;
                    mem_we    <= dm_we;
                    mem_wdata <= dm_wdata;
                end else begin
                    mem_addr  <= if_addr;
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                end
            end else if (nxt == IDLE) begin
                mem_we <= 1'b0;
            end
        end
    end

    // Pipeline hold requests: each stage waits until its own valid pulse.
    always_comb begin
        stall_m = dm_req & ~dm_valid;
        stall_f = (if_req & ~if_valid) | stall_m;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 3;
    localparam int AW         = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [AW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [AW-1:0] dm_wdata;
    logic [AW-1:0] dm_rdata;
    logic          dm_valid;
    logic          stall_f;
    logic          stall_m;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] mem_wdata;
    logic [AW-1:0] mem_rdata;
    logic          mem_ack;

    int tests = 0;
    int fails = 0;

    // Reference model: which side owns the port (0 none, 1 fetch, 2 data),
    // the access it is running, returned data and the starvation tally.
    int            m_gnt;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [AW-1:0] m_wdata;
    logic [AW-1:0] m_if_rdata;
    logic [AW-1:0] m_dm_rdata;
    logic          m_if_valid;
    logic          m_dm_valid;
    logic          m_dropped;
    int            m_starve;

    mem_port_arbiter #(
        .STARVE_MAX(STARVE_MAX),
        .AW        (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .stall_f  (stall_f),
        .stall_m  (stall_m),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt      = 0;
        m_addr     = '0;
        m_we       = 1'b0;
        m_wdata    = '0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
        m_if_valid = 1'b0;
        m_dm_valid = 1'b0;
        m_dropped  = 1'b0;
        m_starve   = 0;
    endtask

    task automatic model_edge();
        logic served;
        logic fin;
        logic see_if;
        logic see_dm;
        int   pick;
        served = (m_gnt == 1) ? if_req : (m_gnt == 2) ? dm_req : 1'b0;
        fin    = (m_gnt != 0) && mem_ack;
        m_if_valid = 1'b0;
        m_dm_valid = 1'b0;
        if (fin) begin
            if (m_gnt == 1) begin
                m_if_rdata = mem_rdata;
                m_if_valid = served && !m_dropped;
            end else begin
                if (!m_we) m_dm_rdata = mem_rdata;
                m_dm_valid = served && !m_dropped;
            end
        end
        if ((m_gnt == 0) || fin) begin
            see_if = if_req && !(fin && (m_gnt == 1) && !dm_req);
            see_dm = dm_req && !(fin && (m_gnt == 2) && !if_req);
            if (see_dm && !(see_if && (m_starve == STARVE_MAX))) pick = 2;
            else if (see_if) pick = 1;
            else pick = 0;
            m_dropped = 1'b0;
            if (pick == 2) begin
                m_addr  = dm_addr;
                m_we    = dm_we;
                m_wdata = dm_wdata;
                if (if_req && (m_starve < STARVE_MAX)) m_starve = m_starve + 1;
            end else if (pick == 1) begin
                m_addr   = if_addr;
                m_we     = 1'b0;
                m_wdata  = '0;
                m_starve = 0;
            end else begin
                m_we = 1'b0;
            end
            m_gnt = pick;
        end else if (!served) begin
            m_dropped = 1'b1;
        end
        if (!if_req) m_starve = 0;
    endtask

    task automatic check_all();
        logic exp_stall_m;
        exp_stall_m = dm_req & ~m_dm_valid;
        chk("mem_req",   32'(mem_req),  32'(m_gnt != 0));
        chk("mem_we",    32'(mem_we),   32'(m_we));
        chk("mem_addr",  mem_addr,      m_addr);
        chk("mem_wdata", mem_wdata,     m_wdata);
        chk("if_valid",  32'(if_valid), 32'(m_if_valid));
        chk("dm_valid",  32'(dm_valid), 32'(m_dm_valid));
        chk("if_rdata",  if_rdata,      m_if_rdata);
        chk("dm_rdata",  dm_rdata,      m_dm_rdata);
        chk("stall_m",   32'(stall_m),  32'(exp_stall_m));
        chk("stall_f",   32'(stall_f),  32'((if_req & ~m_if_valid) | exp_stall_m));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    logic [31:0] starve_seq [8];

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        model_reset();

        // Reset state
        #2 reset = 1'b0;
        #1 check_all();
        step();
        step();
        @(negedge clk) reset = 1'b1;
        step();

        // Spurious ack while idle
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        chk("spur_req",    32'(mem_req),  32'd0);
        chk("spur_ivalid", 32'(if_valid), 32'd0);
        chk("spur_dvalid", 32'(dm_valid), 32'd0);
        mem_ack = 1'b0;
        step();

        // Fetch read, ack two cycles after grant
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        step();
        chk("f_req",   32'(mem_req), 32'd1);
        chk("f_addr",  mem_addr,     32'h0000_0100);
        chk("f_stall", 32'(stall_f), 32'd1);
        step();
        chk("f_stall2", 32'(stall_f), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0050_0093;
        step();
        chk("f_valid", 32'(if_valid), 32'd1);
        chk("f_rdata", if_rdata,      32'h0050_0093);
        chk("f_nostall", 32'(stall_f), 32'd0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        step();
        chk("f_once", 32'(if_valid), 32'd0);
        chk("f_idle", 32'(mem_req),  32'd0);

        // Contention: data first, then fetch
        if_req  = 1'b1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_2000;
        step();
        chk("c_dm_first", mem_addr,     32'h0000_2000);
        chk("c_stall",    32'(stall_f), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_0001;
        step();
        chk("c_dvalid", 32'(dm_valid), 32'd1);
        chk("c_ivalid", 32'(if_valid), 32'd0);
        chk("c_drdata", dm_rdata,      32'hAAAA_0001);
        chk("c_stall2", 32'(stall_f),  32'd1);
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        step();
        chk("c_stall3", 32'(stall_f), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_0002;
        step();
        chk("c_drop_nov", 32'(dm_valid), 32'd0);
        chk("c_if_gnt",   mem_addr,      32'h0000_0100);
        mem_rdata = 32'h00A0_0113;
        step();
        chk("c_ivalid2", 32'(if_valid), 32'd1);
        chk("c_irdata",  if_rdata,      32'h00A0_0113);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        step();

        // Store leaves load data untouched
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_2004;
        dm_wdata = 32'hDEAD_BEEF;
        step();
        chk("s_we",    32'(mem_we),  32'd1);
        chk("s_addr",  mem_addr,     32'h0000_2004);
        chk("s_wdata", mem_wdata,    32'hDEAD_BEEF);
        chk("s_stall", 32'(stall_m), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        step();
        chk("s_valid", 32'(dm_valid), 32'd1);
        chk("s_rdata", dm_rdata,      32'hAAAA_0002);
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        mem_ack = 1'b0;
        step();

        // Starvation: three data grants, one fetch grant, repeat
        starve_seq = '{32'h2000, 32'h2000, 32'h2000, 32'h0100,
                       32'h2000, 32'h2000, 32'h2000, 32'h0100};
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        dm_req  = 1'b1;
        dm_addr = 32'h0000_2000;
        mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("starve_%0d", i), mem_addr, starve_seq[i]);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        mem_ack = 1'b0;
        step();

        // Reset in the middle of a data grant
        dm_req  = 1'b1;
        dm_addr = 32'h0000_2008;
        step();
        chk("r_req", 32'(mem_req), 32'd1);
        if_req  = 1'b1;
        if_addr = 32'h0000_0104;
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("r_req_drop", 32'(mem_req),  32'd0);
        chk("r_addr_clr", mem_addr,      32'd0);
        dm_req = 1'b0;
        step();
        chk("r_novalid", 32'(dm_valid), 32'd0);
        @(negedge clk) reset = 1'b1;
        step();
        chk("r_if_first", mem_addr,     32'h0000_0104);
        chk("r_req2",     32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        chk("r_ivalid", 32'(if_valid), 32'd1);
        if_req  = 1'b0;
        mem_ack = 1'b0;
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) if_req = ~if_req;
            if ($urandom_range(0, 3) == 0) dm_req = ~dm_req;
            if_addr   = $urandom();
            dm_addr   = $urandom();
            dm_wdata  = $urandom();
            dm_we     = $urandom_range(0, 1);
            mem_rdata = $urandom();
            mem_ack   = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                model_reset();
                #1 check_all();
                step();
                @(negedge clk) reset = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: maximum number of consecutive data-side grants issued while fetch is waiting.
REQ-002 Parameter AW, default 32: address and data width.
REQ-003 The port list SHALL be as follows (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low.
- if_req  in  1  fetch-stage request.
- if_addr  in  AW  fetch address (PCF).
- if_rdata  out  AW  fetched instruction.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- dm_req  in  1  memory-stage request.
- dm_we  in  1  1 = store.
- dm_addr  in  AW  data address (ALUResult_M).
- dm_wdata  in  AW  store data (WriteData_M).
- dm_rdata  out  AW  load data.
- dm_valid  out  1  one-cycle pulse; load or store complete.
- stall_f  out  1  hold PC and IF/ID register.
- stall_m  out  1  hold the whole pipeline up to and including MEM.
- mem_req  out  1  unified memory request.
- mem_we  out  1  write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  AW  memory write data.
- mem_rdata  in  AW  memory read data.
- mem_ack  in  1  one-cycle pulse; access complete; variable latency of at least 1 cycle.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, GNT_IF, GNT_DM.
REQ-005 IDLE arbitration:
- dm_req only -> GNT_DM.
- if_req only -> GNT_IF.
- both requests -> GNT_DM, unless starve_cnt == STARVE_MAX, in which case -> GNT_IF.
- neither request -> remain in IDLE.
REQ-006 On entry to a grant state, the arbiter SHALL latch addr, we (0 for fetch) and wdata. mem_req, mem_we, mem_addr and mem_wdata SHALL be driven from these latches (Moore outputs) for as long as the grant is held.
REQ-007 mem_req SHALL be 1 exactly while the state is GNT_IF or GNT_DM.
REQ-008 When mem_ack arrives in GNT_x:
- capture mem_rdata into x_rdata;
- pulse x_valid for one cycle, on the cycle after the ack;
- on a store, dm_rdata SHALL hold its previous value.
REQ-009 On ack, the next state SHALL be chosen by the REQ-005 rules, with the just-served side's request masked for that cycle. This allows back-to-back grants with no idle bubble.
REQ-010 Minimum latency: request seen at edge N -> mem_req high at N+1 -> with ack at N+1, x_valid is high during cycle N+2.
REQ-011 starve_cnt (2 bits at the default parameter, saturating):
- increments on each GNT_DM entry while if_req = 1;
- clears on GNT_IF entry or when if_req = 0.
REQ-012 Stall outputs:
- stall_m = dm_req & ~dm_valid;
- stall_f = (if_req & ~if_valid) | stall_m.
REQ-013 mem_ack received in IDLE SHALL be ignored and SHALL NOT generate a valid pulse.
REQ-014 If the requester deasserts its request mid-grant, the arbiter SHALL still complete the access and SHALL suppress the x_valid pulse.
REQ-015 A fetch grant SHALL NOT be preempted by a later dm_req; dm_req waits for that access to complete.

Reset
REQ-016 While reset = 0, asynchronously:
- state = IDLE;
- mem_req = 0, mem_we = 0;
- if_valid = 0, dm_valid = 0;
- starve_cnt = 0;
- if_rdata, dm_rdata, mem_addr, mem_wdata = 0.
REQ-017 Reset asserted mid-grant SHALL abandon the access with no valid pulse. The first request after reset release SHALL be arbitrated afresh.

Structure
REQ-018 The state enum (IDLE/GNT_IF/GNT_DM) and the grant-source enum SHALL live in the shared package riscv_mem_pkg.
REQ-019 The saturating starvation counter SHALL be the sub-module arb_starve_cnt. All other logic SHALL be inline.

Verification
REQ-020 Fetch read: if_req=1, if_addr=0x100, ack after 2 cycles with mem_rdata=0x00500093 -> exactly one if_valid pulse with if_rdata=0x00500093; stall_f high until that pulse.
REQ-021 Contention: if_req and dm_req (load, 0x2000) both asserted from IDLE -> GNT_DM first; dm_valid precedes if_valid; stall_f is high throughout.
REQ-022 Starvation: dm_req held high with ack=1 every grant and if_req high -> 3 consecutive DM grants, then a GNT_IF grant, then DM grants resume.
REQ-023 Store: dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF -> mem_we=1 with that address and data; dm_valid pulses; dm_rdata is unchanged.
REQ-024 Reset mid-grant: reset=0 while in GNT_DM before ack -> mem_req falls in the same cycle; no dm_valid pulse; after release, a pending if_req is granted first.
REQ-025 A spurious mem_ack in IDLE produces no valid pulse and no state change.
